// File: rtl/id_stage.sv
// Decode stage: decodes an LA32 integer subset, reads the register file, resolves branches
// and holds on RAW hazards. Define ID_FORWARD_EN to take operands from the execute/memory buses.
module id_stage #(
    parameter int FS_TO_DS_WD = 64,
    parameter int DS_TO_ES_WD = 148
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [FS_TO_DS_WD-1:0] fs_to_ds_bus,
    output logic                   ds_allow_in,
    output logic [32:0]            br_bus,
    input  logic                   es_allow_in,
    output logic                   ds_to_es_valid,
    output logic [DS_TO_ES_WD-1:0] ds_to_es_bus,
    input  logic [39:0]            es_fwd_bus,
    input  logic [38:0]            ms_fwd_bus,
    input  logic [37:0]            ws_rf_bus
);

    logic                   ds_valid;
    logic                   br_cancel;
    logic                   ds_ready_go;
    logic                   accept;
    logic                   drop_next;
    logic                   br_taken;
    logic [31:0]            br_target;
    logic [FS_TO_DS_WD-1:0] fs_bus_q;

    assign accept    = ds_allow_in && fs_to_ds_valid;
    // A taken branch this cycle also drops a fetch accepted on the same edge.
    assign drop_next = br_cancel || (br_taken && es_allow_in);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid  <= 1'b0;
            br_cancel <= 1'b0;
            fs_bus_q  <= '0;
        end else begin
            if (ds_allow_in) begin
                ds_valid <= fs_to_ds_valid && !drop_next;
            end
            if (accept) begin
                fs_bus_q  <= fs_to_ds_bus;
                br_cancel <= 1'b0;
            end else begin
                br_cancel <= drop_next;
            end
        end
    end

    logic [31:0] ds_pc;
    logic [31:0] inst;
    assign ds_pc = fs_bus_q[63:32];
    assign inst  = fs_bus_q[31:0];

    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic [11:0] si12;
    logic [19:0] si20;
    logic [15:0] offs16;
    assign rd     = inst[4:0];
    assign rj     = inst[9:5];
    assign rk     = inst[14:10];
    assign si12   = inst[21:10];
    assign si20   = inst[24:5];
    assign offs16 = inst[25:10];

    logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
    logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
    logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;

    assign inst_add   = inst[31:15] == 17'h00020;
    assign inst_sub   = inst[31:15] == 17'h00022;
    assign inst_slt   = inst[31:15] == 17'h00024;
    assign inst_sltu  = inst[31:15] == 17'h00025;
    assign inst_nor   = inst[31:15] == 17'h00028;
    assign inst_and   = inst[31:15] == 17'h00029;
    assign inst_or    = inst[31:15] == 17'h0002a;
    assign inst_xor   = inst[31:15] == 17'h0002b;
    assign inst_slli  = inst[31:15] == 17'h00081;
    assign inst_srli  = inst[31:15] == 17'h00089;
    assign inst_srai  = inst[31:15] == 17'h00091;
    assign inst_addi  = inst[31:22] == 10'h00a;
    assign inst_ld    = inst[31:22] == 10'h0a2;
    assign inst_st    = inst[31:22] == 10'h0a6;
    assign inst_lu12i = inst[31:25] == 7'h0a;
    assign inst_jirl  = inst[31:26] == 6'h13;
    assign inst_b     = inst[31:26] == 6'h14;
    assign inst_bl    = inst[31:26] == 6'h15;
    assign inst_beq   = inst[31:26] == 6'h16;
    assign inst_bne   = inst[31:26] == 6'h17;

    logic reg_op;
    logic shift_imm;
    logic src1_used;
    logic src2_used;
    logic sel_rd;
    assign reg_op    = inst_add | inst_sub | inst_slt | inst_sltu |
                       inst_and | inst_or | inst_nor | inst_xor;
    assign shift_imm = inst_slli | inst_srli | inst_srai;
    assign src1_used = reg_op | shift_imm | inst_addi | inst_ld | inst_st |
                       inst_jirl | inst_beq | inst_bne;
    assign sel_rd    = inst_st | inst_beq | inst_bne;
    assign src2_used = reg_op | sel_rd;

    logic [4:0] raddr2;
    assign raddr2 = sel_rd ? rd : rk;

    logic        ws_we;
    logic [4:0]  ws_waddr;
    logic [31:0] ws_wdata;
    assign ws_we    = ws_rf_bus[37];
    assign ws_waddr = ws_rf_bus[36:32];
    assign ws_wdata = ws_rf_bus[31:0];

    logic [31:0] rf [32];

    // NOTE: the register file is cleared on reset because r1..r31 must read zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (ws_we && ws_waddr != 5'd0) begin
            rf[ws_waddr] <= ws_wdata;
        end
    end

    logic [31:0] rf_rj;
    logic [31:0] rf_r2;
    assign rf_rj = (rj == 5'd0)                      ? 32'd0    :
                   (ws_we && ws_waddr == rj)         ? ws_wdata : rf[rj];
    assign rf_r2 = (raddr2 == 5'd0)                  ? 32'd0    :
                   (ws_we && ws_waddr == raddr2)     ? ws_wdata : rf[raddr2];

    logic        es_valid, es_we, es_is_load;
    logic [4:0]  es_dest;
    logic [31:0] es_value;
    logic        ms_valid, ms_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_value;
    assign {es_valid, es_we, es_dest, es_is_load, es_value} = es_fwd_bus;
    assign {ms_valid, ms_we, ms_dest, ms_value}             = ms_fwd_bus;

    logic es_hit1, es_hit2, ms_hit1, ms_hit2;
    assign es_hit1 = src1_used && rj != 5'd0     && es_valid && es_we && es_dest == rj;
    assign es_hit2 = src2_used && raddr2 != 5'd0 && es_valid && es_we && es_dest == raddr2;
    assign ms_hit1 = src1_used && rj != 5'd0     && ms_valid && ms_we && ms_dest == rj;
    assign ms_hit2 = src2_used && raddr2 != 5'd0 && ms_valid && ms_we && ms_dest == raddr2;

    logic [31:0] rj_value;
    logic [31:0] r2_value;
    logic        stall;

`ifdef ID_FORWARD_EN
    assign rj_value = es_hit1 ? es_value : ms_hit1 ? ms_value : rf_rj;
    assign r2_value = es_hit2 ? es_value : ms_hit2 ? ms_value : rf_r2;
    // A load's value is not known until after execute, so it still has to wait.
    assign stall    = (es_hit1 || es_hit2) && es_is_load;
`else
    assign rj_value = rf_rj;
    assign r2_value = rf_r2;
    assign stall    = es_hit1 || es_hit2 || ms_hit1 || ms_hit2;
    logic unused_fwd;
    assign unused_fwd = ^{es_is_load, es_value, ms_value};
`endif

    assign ds_ready_go    = !stall;
    assign ds_allow_in    = !ds_valid || (ds_ready_go && es_allow_in);
    assign ds_to_es_valid = ds_valid && ds_ready_go;

    logic [31:0] br_offs16;
    logic [31:0] br_offs26;
    logic        br_cond;
    assign br_offs16 = {{14{offs16[15]}}, offs16, 2'b00};
    assign br_offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    assign br_cond   = inst_b | inst_bl | inst_jirl |
                       (inst_beq && rj_value == r2_value) |
                       (inst_bne && rj_value != r2_value);
    assign br_taken  = ds_valid && ds_ready_go && br_cond;
    assign br_target = inst_jirl           ? rj_value + br_offs16 :
                       (inst_b | inst_bl)  ? ds_pc + br_offs26    : ds_pc + br_offs16;
    assign br_bus    = br_taken ? {1'b1, br_target} : 33'd0;

    // alu_op one-hot, bit 0..11: add sub slt sltu and nor or xor sll srl sra lui
    logic [11:0] alu_op;
    assign alu_op = {inst_lu12i, inst_srai, inst_srli, inst_slli, inst_xor, inst_or,
                     inst_nor, inst_and, inst_sltu, inst_slt, inst_sub,
                     inst_add | inst_addi | inst_ld | inst_st | inst_jirl | inst_bl};

    logic        dest_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    assign dest_we = reg_op | shift_imm | inst_addi | inst_lu12i | inst_ld | inst_jirl | inst_bl;
    assign dest    = inst_bl ? 5'd1 : rd;
    // Link value is formed in execute as pc + 4.
    assign src1    = (inst_bl | inst_jirl) ? ds_pc : inst_lu12i ? 32'd0 : rj_value;

    always_comb begin
        src2 = r2_value;
        if (inst_bl || inst_jirl) begin
            src2 = 32'd4;
        end else if (inst_lu12i) begin
            src2 = {si20, 12'd0};
        end else if (shift_imm) begin
            src2 = {27'd0, rk};
        end else if (inst_addi || inst_ld || inst_st) begin
            src2 = {{20{si12[11]}}, si12};
        end
    end

    assign ds_to_es_bus = {alu_op, inst_ld, inst_st, dest_we, dest,
                           src1, src2, r2_value, ds_pc};

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations adapt to ID_FORWARD_EN.
module tb_id_stage;

    logic         clk;
    logic         reset;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allow_in;
    logic [32:0]  br_bus;
    logic         es_allow_in;
    logic         ds_to_es_valid;
    logic [147:0] ds_to_es_bus;
    logic [39:0]  es_fwd_bus;
    logic [38:0]  ms_fwd_bus;
    logic [37:0]  ws_rf_bus;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allow_in    (ds_allow_in),
        .br_bus         (br_bus),
        .es_allow_in    (es_allow_in),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_fwd_bus     (es_fwd_bus),
        .ms_fwd_bus     (ms_fwd_bus),
        .ws_rf_bus      (ws_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [11:0] o_alu_op  = ds_to_es_bus[147:136];
    wire [2:0]  o_ctl     = ds_to_es_bus[135:133];
    wire [4:0]  o_dest    = ds_to_es_bus[132:128];
    wire [31:0] o_src1    = ds_to_es_bus[127:96];
    wire [31:0] o_src2    = ds_to_es_bus[95:64];
    wire [31:0] o_pc      = ds_to_es_bus[31:0];

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] add_w(input int d, input int j, input int k);
        return 32'h0010_0000 | (32'(k) << 10) | (32'(j) << 5) | 32'(d);
    endfunction

    task automatic ws_write(input logic [4:0] a, input logic [31:0] v);
        ws_rf_bus = {1'b1, a, v};
        tick();
        ws_rf_bus = '0;
    endtask

    task automatic feed(input logic [31:0] pc, input logic [31:0] ins);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, ins};
    endtask

    initial begin
        reset          = 1'b1;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        es_allow_in    = 1'b1;
        es_fwd_bus     = '0;
        ms_fwd_bus     = '0;
        ws_rf_bus      = '0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_es_valid", 64'(ds_to_es_valid), 64'd0);
        check("rst_br_bus",   64'(br_bus),         64'd0);
        check("rst_allow_in", 64'(ds_allow_in),    64'd1);

        // add.w r3,r1,r2 with r1=5, r2=7
        ws_write(5'd1, 32'd5);
        ws_write(5'd2, 32'd7);
        feed(32'h1c00_0000, 32'h0010_0823);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("add_valid",   64'(ds_to_es_valid), 64'd1);
        check("add_src1",    64'(o_src1),         64'd5);
        check("add_src2",    64'(o_src2),         64'd7);
        check("add_dest",    64'(o_dest),         64'd3);
        check("add_ctl",     64'(o_ctl),          64'b001);
        check("add_alu_op",  64'(o_alu_op),       64'h001);
        check("add_pc",      64'(o_pc),           64'h1c00_0000);
        tick();
        check("add_drained", 64'(ds_to_es_valid), 64'd0);

        // beq r1,r2,+8 taken; the sequential instruction is dropped
        ws_write(5'd1, 32'd3);
        ws_write(5'd2, 32'd3);
        feed(32'h1c00_0010, 32'h5800_0822);
        tick();
        feed(32'h1c00_0014, add_w(3, 1, 2));
        #1;
        check("beq_br_bus",  64'(br_bus),         {31'd0, 1'b1, 32'h1c00_0018});
        check("beq_allow",   64'(ds_allow_in),    64'd1);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("beq_drop",    64'(ds_to_es_valid), 64'd0);
        check("beq_br_idle", 64'(br_bus),         64'd0);
        feed(32'h1c00_0018, add_w(3, 1, 2));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("tgt_valid",   64'(ds_to_es_valid), 64'd1);
        check("tgt_pc",      64'(o_pc),           64'h1c00_0018);
        check("tgt_src1",    64'(o_src1),         64'd3);
        tick();

        // Same beq with r1 != r2 -> not taken, pc+4 flows
        ws_write(5'd2, 32'd9);
        feed(32'h1c00_0010, 32'h5800_0822);
        tick();
        feed(32'h1c00_0014, add_w(3, 1, 2));
        #1;
        check("beqnt_taken", 64'(br_bus[32]),     64'd0);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("beqnt_valid", 64'(ds_to_es_valid), 64'd1);
        check("beqnt_pc",    64'(o_pc),           64'h1c00_0014);
        check("beqnt_src2",  64'(o_src2),         64'd9);
        tick();

        // Load-use on r4 stalls in both configurations
        es_fwd_bus = {1'b1, 1'b1, 5'd4, 1'b1, 32'hdead_beef};
        feed(32'h1c00_0030, add_w(5, 4, 0));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("ld_stall_allow", 64'(ds_allow_in),    64'd0);
        check("ld_stall_valid", 64'(ds_to_es_valid), 64'd0);
        tick();
        check("ld_stall_hold",  64'(ds_allow_in),    64'd0);
        es_fwd_bus = '0;
        ws_rf_bus  = {1'b1, 5'd4, 32'h44};
        #1;
        check("ld_rel_valid",   64'(ds_to_es_valid), 64'd1);
        check("ld_rel_src1",    64'(o_src1),         64'h44);
        check("ld_rel_dest",    64'(o_dest),         64'd5);
        tick();
        ws_rf_bus = '0;

        // Non-load producer of r6 in execute
        es_fwd_bus = {1'b1, 1'b1, 5'd6, 1'b0, 32'h10};
        feed(32'h1c00_0040, add_w(7, 6, 0));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
`ifdef ID_FORWARD_EN
        check("fwd_valid",  64'(ds_to_es_valid), 64'd1);
        check("fwd_src1",   64'(o_src1),         64'h10);
        check("fwd_allow",  64'(ds_allow_in),    64'd1);
        tick();
        es_fwd_bus = '0;
`else
        check("raw_es_stall", 64'(ds_to_es_valid), 64'd0);
        check("raw_es_allow", 64'(ds_allow_in),    64'd0);
        tick();
        es_fwd_bus = '0;
        ms_fwd_bus = {1'b1, 1'b1, 5'd6, 32'h10};
        #1;
        check("raw_ms_stall", 64'(ds_to_es_valid), 64'd0);
        tick();
        ms_fwd_bus = '0;
        ws_rf_bus  = {1'b1, 5'd6, 32'h10};
        #1;
        check("raw_ws_valid", 64'(ds_to_es_valid), 64'd1);
        check("raw_ws_src1",  64'(o_src1),         64'h10);
        tick();
        ws_rf_bus = '0;
`endif

        // bne under a load-use stall: stall wins, branch resolves afterwards
        es_fwd_bus = {1'b1, 1'b1, 5'd1, 1'b1, 32'h0};
        feed(32'h1c00_0020, 32'h5c00_0822);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("bst_taken",  64'(br_bus[32]),  64'd0);
        check("bst_allow",  64'(ds_allow_in), 64'd0);
        tick();
        es_fwd_bus = '0;
        #1;
        check("bst_br_bus", 64'(br_bus),      {31'd0, 1'b1, 32'h1c00_0028});
        tick();
        feed(32'h1c00_0024, add_w(3, 1, 2));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("bst_drop",   64'(ds_to_es_valid), 64'd0);

        // Unknown encoding decodes as NOP
        feed(32'h1c00_0028, 32'hffff_ffff);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("nop_valid",  64'(ds_to_es_valid), 64'd1);
        check("nop_ctl",    64'(o_ctl),          64'd0);
        tick();

        // Reset in the middle of a stall; register file returns to zero
        es_fwd_bus = {1'b1, 1'b1, 5'd4, 1'b1, 32'h0};
        feed(32'h1c00_0050, add_w(5, 4, 0));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("mid_stall",  64'(ds_allow_in), 64'd0);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        es_fwd_bus = '0;
        #1;
        check("rst2_valid", 64'(ds_to_es_valid), 64'd0);
        check("rst2_allow", 64'(ds_allow_in),    64'd1);
        feed(32'h1c00_0060, add_w(3, 1, 2));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        check("rst2_src1",  64'(o_src1), 64'd0);
        check("rst2_src2",  64'(o_src2), 64'd0);
        tick();

        // Writes to r0 are never visible
        feed(32'h1c00_0070, add_w(8, 0, 0));
        tick();
        fs_to_ds_valid = 1'b0;
        ws_rf_bus      = {1'b1, 5'd0, 32'h123};
        #1;
        check("r0_src1",    64'(o_src1), 64'd0);
        tick();
        ws_rf_bus = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
